popcount_sequencer: RTL and testbench
=====================================

# popcount_sequencer

Multi-cycle controller that computes the number of set bits in a WIDTH-bit word by streaming it, three bits per cycle, through the team's combinational 3-input ones-counter cell (OC1: a, b, c in; y1:y0 = number of ones). The block owns the start/busy/done handshake, the chunk counter and the accumulator. It drives the OC1 inputs and reads its 2-bit result, so a single small cell serves words of any width.

## Interface
- WIDTH, 12, input word width; must be a multiple of 3 and at least 3
- NCH (derived), WIDTH/3, number of 3-bit chunks
- CW (derived), $clog2(WIDTH+1), result width
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- start  input  1  request; sampled only in IDLE
- din  input  WIDTH  word to count; sampled on the accepting edge
- oc_a, oc_b, oc_c  output  1 each  drive OC1 inputs a, b, c
- oc_y1, oc_y0  input  1 each  OC1 result, {oc_y1,oc_y0} in 0..3
- busy  output  1  high while in RUN
- done  output  1  one-cycle completion pulse
- count  output  CW  last completed result

## Operation
- FSM states: IDLE, RUN, DONE; reset state is IDLE.
- IDLE:
  - start=1 → load shift register with din, clear accumulator, clear chunk index, go to RUN.
  - start=0 → stay in IDLE.
- RUN, chunk k (k = 0..NCH-1, LSB chunk first):
  - oc_a = din[3k+2], oc_b = din[3k+1], oc_c = din[3k], taken from the low 3 bits of the shift register.
  - Each edge: acc ← acc + {oc_y1,oc_y0}, zero-extended to CW; shift register >> 3; index + 1.
  - On the edge where index = NCH-1: count ← acc + {oc_y1,oc_y0}, go to DONE.
- DONE: done=1 for exactly one cycle, then unconditionally go to IDLE.
- start is ignored in RUN and DONE, with no queuing. A start held high through DONE is accepted in the following IDLE cycle.
- oc_a/b/c = 0 outside RUN. busy = (state==RUN). done = (state==DONE). All three are Moore outputs.
- Arithmetic: the accumulator is CW bits wide and cannot overflow, since the maximum is 3·NCH = WIDTH.
- count holds its value until the next completion. It is not cleared by start.
- The OC1 path is combinational within one cycle, so there are no wait states.

## Timing
- Reset (asynchronous, any time including mid-RUN):
  - state=IDLE; busy=0, done=0, count=0, oc_a/b/c=0.
  - Accumulator, shift register and index cleared.
  - The in-flight word is discarded and no done pulse is issued.
- Start accepted at edge E0: busy=1 from E0 to E_NCH.
- Chunk k is presented between edges E_k and E_k+1 and accumulated at E_k+1.
- At E_NCH: count updated, busy=0, done=1. At E_NCH+1: done=0.
- Latency from the accepting edge to done rising is NCH cycles. Throughput is one word per NCH+2 cycles when start is held high.
- din may change after E0 without affecting the result.

## Test plan
- Reset values: assert rst_n=0 mid-cycle → immediately busy=0, done=0, count=0, oc_a/b/c=0.
- Full word (WIDTH=12): start with din=12'hFFF → busy for 4 cycles, each chunk presents oc_a/b/c=111, done pulses at E4 with count=12. Then din=12'h000 → count=0.
- Chunk order: din=12'b001_010_100_111 → oc_{a,b,c} sequence 111, 100, 010, 001, matching chunks k=0..3. A bench OC1 model returns 3,1,1,1 → count=6.
- Mixed value: din=12'hA5C → count=6. Changing din to 12'hFFF at E1 → result is still 6.
- Start while busy: pulse start with din=12'hFFF at E2 of a 12'h001 run → ignored, count=1, single done pulse. Start held high continuously → new run accepted the cycle after DONE.
- Reset mid-run: rst_n=0 at E2 → IDLE, no done pulse, count=0. A new start afterwards completes normally.

Source files
------------

// File: rtl/popcount_sequencer.sv
// Multi-cycle popcount controller: streams a WIDTH-bit word three bits per cycle
// through an external 3-input ones-counter cell and accumulates its 2-bit results.
module popcount_sequencer #(
  parameter  int WIDTH = 12,
  localparam int NCH   = WIDTH / 3,
  localparam int CW    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] din,
  output logic             oc_a,
  output logic             oc_b,
  output logic             oc_c,
  input  logic             oc_y1,
  input  logic             oc_y0,
  output logic             busy,
  output logic             done,
  output logic [CW-1:0]    count
);

  localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] sr;
  logic [CW-1:0]    acc;
  logic [IW-1:0]    idx;
  logic [CW-1:0]    y_ext;
  logic [CW-1:0]    acc_next;

  // The cell result is at most 3, so zero-extension into CW bits is lossless.
  assign y_ext    = CW'({oc_y1, oc_y0});
  assign acc_next = acc + y_ext;

  // The low three shift-register bits are the current chunk; gated so the cell sees zeros outside RUN.
  assign oc_a = busy & sr[2];
  assign oc_b = busy & sr[1];
  assign oc_c = busy & sr[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      count <= '0;
      sr    <= '0;
      acc   <= '0;
      idx   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            sr    <= din;
            acc   <= '0;
            idx   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          acc <= acc_next;
          sr  <= sr >> 3;
          idx <= idx + 1'b1;
          if (idx == IW'(NCH - 1)) begin
            count <= acc_next;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_popcount_sequencer.sv
// Self-checking bench for popcount_sequencer (WIDTH=12) with a behavioural OC1 cell
// and a reference model that counts bits and slices chunks arithmetically.
module tb_popcount_sequencer;

  localparam int WIDTH = 12;
  localparam int NCH   = WIDTH / 3;
  localparam int CW    = $clog2(WIDTH + 1);

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             start = 1'b0;
  logic [WIDTH-1:0] din = '0;
  logic             oc_a, oc_b, oc_c;
  logic             oc_y1, oc_y0;
  logic             busy, done;
  logic [CW-1:0]    count;

  int total = 0;
  int bad   = 0;
  int done_cnt = 0;

  popcount_sequencer #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .din   (din),
    .oc_a  (oc_a),
    .oc_b  (oc_b),
    .oc_c  (oc_c),
    .oc_y1 (oc_y1),
    .oc_y0 (oc_y0),
    .busy  (busy),
    .done  (done),
    .count (count)
  );

  // OC1 cell: number of ones among a, b, c
  assign {oc_y1, oc_y0} = 2'(int'(oc_a) + int'(oc_b) + int'(oc_c));

  always #5 clk = ~clk;

  always @(negedge clk) if (done === 1'b1) done_cnt++;

  initial begin
    #200000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int ref_pop(input logic [WIDTH-1:0] w);
    int n = 0;
    for (int i = 0; i < WIDTH; i++) n += int'(w[i]);
    return n;
  endfunction

  // Chunk k as {a,b,c} = {w[3k+2], w[3k+1], w[3k]}
  function automatic int ref_chunk(input logic [WIDTH-1:0] w, input int k);
    return int'((w >> (3 * k)) & WIDTH'(7));
  endfunction

  task automatic run_word(input string tag, input logic [WIDTH-1:0] w, input logic [WIDTH-1:0] w_after);
    din   = w;
    start = 1'b1;
    tick();
    start = 1'b0;
    din   = w_after;
    for (int k = 0; k < NCH; k++) begin
      check({tag, "_busy"}, busy, 1);
      check({tag, "_chunk"}, {oc_a, oc_b, oc_c}, ref_chunk(w, k));
      check({tag, "_nodone"}, done, 0);
      tick();
    end
    check({tag, "_busy_end"}, busy, 0);
    check({tag, "_done"}, done, 1);
    check({tag, "_count"}, count, ref_pop(w));
    tick();
    check({tag, "_done_low"}, done, 0);
    check({tag, "_idle_oc"}, {oc_a, oc_b, oc_c}, 0);
  endtask

  initial begin
    int d0;
    logic [WIDTH-1:0] w1, w2, wr;

    // Asynchronous reset mid-cycle
    #2 rst_n = 1'b0;
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_count", count, 0);
    check("rst_oc", {oc_a, oc_b, oc_c}, 0);
    #11 rst_n = 1'b1;
    tick();
    check("idle_busy", busy, 0);

    run_word("full", 12'hFFF, 12'hFFF);
    run_word("zero", 12'h000, 12'h000);
    run_word("order", 12'b001_010_100_111, 12'h000);
    run_word("mixed", 12'hA5C, 12'hFFF);

    for (int i = 0; i < 8; i++) begin
      wr = WIDTH'($urandom);
      run_word("rand", wr, WIDTH'($urandom));
    end

    // start during RUN must be ignored
    d0 = done_cnt;
    din = 12'h001;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    din = 12'hFFF;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    check("ign_done", done, 1);
    check("ign_count", count, 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("ign_busy", busy, 0);
    end
    check("ign_pulses", done_cnt - d0, 1);

    // start held high: next word accepted in the IDLE cycle after DONE
    w1 = 12'h0F3;
    w2 = 12'h7E1;
    din = w1;
    start = 1'b1;
    for (int i = 0; i < NCH + 1; i++) tick();
    check("held_done1", done, 1);
    check("held_count1", count, ref_pop(w1));
    din = w2;
    tick();
    check("held_gap_busy", busy, 0);
    check("held_gap_done", done, 0);
    tick();
    start = 1'b0;
    check("held_busy2", busy, 1);
    check("held_chunk2", {oc_a, oc_b, oc_c}, ref_chunk(w2, 0));
    for (int i = 0; i < NCH; i++) tick();
    check("held_done2", done, 1);
    check("held_count2", count, ref_pop(w2));
    tick();

    // Reset mid-run discards the word
    d0 = done_cnt;
    din = 12'hFFF;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    check("mrst_busy", busy, 0);
    check("mrst_done", done, 0);
    check("mrst_count", count, 0);
    check("mrst_oc", {oc_a, oc_b, oc_c}, 0);
    #3 rst_n = 1'b1;
    for (int i = 0; i < NCH + 2; i++) tick();
    check("mrst_idle", busy, 0);
    check("mrst_nopulse", done_cnt - d0, 0);
    check("mrst_count_hold", count, 0);
    run_word("after_rst", 12'h5A3, 12'h000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
